// File: rtl/fpu_pkg.sv
// Shared definitions for the fpu issue controller: op/rmode encodings, flag bit
// positions, the canonical quiet NaN and the response entry layout.
package fpu_pkg;

   localparam logic [2:0] FPU_ADD = 3'd0;
   localparam logic [2:0] FPU_SUB = 3'd1;
   localparam logic [2:0] FPU_MUL = 3'd2;
   localparam logic [2:0] FPU_DIV = 3'd3;

   localparam logic [1:0] RM_NEAREST = 2'd0;
   localparam logic [1:0] RM_ZERO    = 2'd1;
   localparam logic [1:0] RM_PINF    = 2'd2;
   localparam logic [1:0] RM_NINF    = 2'd3;

   localparam int FLG_SNAN = 7;
   localparam int FLG_QNAN = 6;
   localparam int FLG_INF  = 5;
   localparam int FLG_INE  = 4;
   localparam int FLG_OVF  = 3;
   localparam int FLG_UNF  = 2;
   localparam int FLG_DBZ  = 1;
   localparam int FLG_ZERO = 0;

   localparam logic [31:0] QNAN       = 32'h7FC0_0000;
   localparam logic [7:0]  QNAN_FLAGS = 8'(1 << FLG_QNAN);

   // The response struct is sized by this width; the top's TAG_W must match it.
   localparam int FPU_TAG_W = 4;

   typedef struct packed {
      logic [31:0]          result;
      logic [7:0]           flags;
      logic [FPU_TAG_W-1:0] tag;
   } fpu_rsp_t;

   function automatic logic op_illegal(input logic [2:0] op);
      return op[2];
   endfunction

endpackage

// File: rtl/fpu_rsp_fifo.sv
// Show-ahead response FIFO with registered storage; the head entry is always
// visible on rd_data_o and count_o feeds the issue controller's credit sum.
module fpu_rsp_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4,
   localparam int CW = $clog2(DEPTH + 1),
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en_i,
   input  logic [WIDTH-1:0] wr_data_i,
   input  logic             rd_en_i,
   output logic [WIDTH-1:0] rd_data_o,
   output logic             valid_o,
   output logic [CW-1:0]    count_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]    cnt_q;
   logic             do_rd, do_wr;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign do_rd = rd_en_i && (cnt_q != '0);
   // When full, a write lands in the slot the simultaneous pop is vacating.
   assign do_wr = wr_en_i && ((cnt_q != CW'(DEPTH)) || do_rd);

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         if (do_wr) begin
            mem_q[wr_ptr_q] <= wr_data_i;
            wr_ptr_q        <= ptr_inc(wr_ptr_q);
         end
         if (do_rd) rd_ptr_q <= ptr_inc(rd_ptr_q);
         cnt_q <= cnt_q + CW'(do_wr) - CW'(do_rd);
      end
   end

   assign rd_data_o = mem_q[rd_ptr_q];
   assign valid_o   = (cnt_q != '0);
   assign count_o   = cnt_q;

endmodule

// File: rtl/fpu_issue_ctrl.sv
// Issue controller for the fixed-latency fpu core: registers requests onto the
// core, tracks them with a latency-matched tag pipeline and returns results in order.
module fpu_issue_ctrl
   import fpu_pkg::*;
#(
   parameter int FPU_LAT = 4,
   parameter int DEPTH   = 4,
   parameter int TAG_W   = FPU_TAG_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [2:0]       req_op,
   input  logic [1:0]       req_rmode,
   input  logic [31:0]      req_opa,
   input  logic [31:0]      req_opb,
   input  logic [TAG_W-1:0] req_tag,
   output logic [2:0]       fpu_op,
   output logic [1:0]       fpu_rmode,
   output logic [31:0]      fpu_opa,
   output logic [31:0]      fpu_opb,
   input  logic [31:0]      fpu_out,
   input  logic [7:0]       fpu_flags,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [31:0]      rsp_result,
   output logic [7:0]       rsp_flags,
   output logic [TAG_W-1:0] rsp_tag,
   output logic             busy
);

   localparam int CW = $clog2(DEPTH + 1);

   logic             rst_hold_q;
   logic [CW-1:0]    inflight_q, inflight_d, fifo_cnt, credits;
   logic             issue, wr_en, pop, fifo_vld;
   logic [FPU_LAT:0] pipe_vld_q, pipe_ill_q;
   logic [TAG_W-1:0] pipe_tag_q [FPU_LAT+1];
   logic [2:0]       fpu_op_q;
   logic [1:0]       fpu_rmode_q;
   logic [31:0]      fpu_opa_q, fpu_opb_q;
   fpu_rsp_t         wr_entry, rd_entry;

   // Every accepted op holds a credit until its response is popped, so the
   // FIFO always has room for whatever the non-stallable core delivers.
   assign credits    = inflight_q + fifo_cnt;
   assign req_ready  = !rst_hold_q && (credits < CW'(DEPTH));
   assign busy       = (credits != '0);
   assign issue      = req_valid && req_ready;
   assign wr_en      = pipe_vld_q[FPU_LAT];
   assign pop        = fifo_vld && rsp_ready;
   assign inflight_d = inflight_q + CW'(issue) - CW'(wr_en);

   always_comb begin
      wr_entry.tag = pipe_tag_q[FPU_LAT];
      if (pipe_ill_q[FPU_LAT]) begin
         wr_entry.result = QNAN;
         wr_entry.flags  = QNAN_FLAGS;
      end else begin
         wr_entry.result = fpu_out;
         wr_entry.flags  = fpu_flags;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rst_hold_q  <= 1'b1;
         inflight_q  <= '0;
         fpu_op_q    <= '0;
         fpu_rmode_q <= '0;
         fpu_opa_q   <= '0;
         fpu_opb_q   <= '0;
         pipe_vld_q  <= '0;
         pipe_ill_q  <= '0;
         for (int k = 0; k <= FPU_LAT; k++) pipe_tag_q[k] <= '0;
      end else begin
         rst_hold_q <= 1'b0;
         inflight_q <= inflight_d;
         if (issue) begin
            fpu_op_q    <= op_illegal(req_op) ? FPU_ADD : req_op;
            fpu_rmode_q <= req_rmode;
            fpu_opa_q   <= req_opa;
            fpu_opb_q   <= req_opb;
         end
         // Stage FPU_LAT lines up with the core output for the op issued FPU_LAT edges ago.
         pipe_vld_q    <= {pipe_vld_q[FPU_LAT-1:0], issue};
         pipe_ill_q    <= {pipe_ill_q[FPU_LAT-1:0], op_illegal(req_op)};
         pipe_tag_q[0] <= req_tag;
         for (int k = 1; k <= FPU_LAT; k++) pipe_tag_q[k] <= pipe_tag_q[k-1];
      end
   end

   fpu_rsp_fifo #(
      .WIDTH($bits(fpu_rsp_t)),
      .DEPTH(DEPTH)
   ) u_rsp_fifo (
      .clk       (clk),
      .rst       (rst),
      .wr_en_i   (wr_en),
      .wr_data_i (wr_entry),
      .rd_en_i   (pop),
      .rd_data_o (rd_entry),
      .valid_o   (fifo_vld),
      .count_o   (fifo_cnt)
   );

   assign fpu_op     = fpu_op_q;
   assign fpu_rmode  = fpu_rmode_q;
   assign fpu_opa    = fpu_opa_q;
   assign fpu_opb    = fpu_opb_q;
   assign rsp_valid  = fifo_vld;
   assign rsp_result = rd_entry.result;
   assign rsp_flags  = rd_entry.flags;
   assign rsp_tag    = rd_entry.tag;

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Bench for fpu_issue_ctrl: a latency-matched stand-in for the fpu core, a
// scoreboard of expected responses, a vector table and corner-case sequences.
module tb_fpu_issue_ctrl;
   import fpu_pkg::*;

   localparam int FPU_LAT = 4;
   localparam int DEPTH   = 4;
   localparam int TAG_W   = 4;

   logic             clk = 1'b0;
   logic             rst;
   logic             req_valid, req_ready;
   logic [2:0]       req_op;
   logic [1:0]       req_rmode;
   logic [31:0]      req_opa, req_opb;
   logic [TAG_W-1:0] req_tag;
   logic [2:0]       fpu_op;
   logic [1:0]       fpu_rmode;
   logic [31:0]      fpu_opa, fpu_opb, fpu_out;
   logic [7:0]       fpu_flags;
   logic             rsp_valid, rsp_ready;
   logic [31:0]      rsp_result;
   logic [7:0]       rsp_flags;
   logic [TAG_W-1:0] rsp_tag;
   logic             busy;

   always #5 clk = ~clk;

   fpu_issue_ctrl #(.FPU_LAT(FPU_LAT), .DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
      .req_rmode(req_rmode), .req_opa(req_opa), .req_opb(req_opb), .req_tag(req_tag),
      .fpu_op(fpu_op), .fpu_rmode(fpu_rmode), .fpu_opa(fpu_opa), .fpu_opb(fpu_opb),
      .fpu_out(fpu_out), .fpu_flags(fpu_flags),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
      .rsp_flags(rsp_flags), .rsp_tag(rsp_tag), .busy(busy)
   );

   // Core stand-in: exact answers for the cases the tests name, a mixing hash otherwise.
   function automatic logic [39:0] fpu_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      if (op == FPU_ADD && a == 32'h3F80_0000 && b == 32'h4000_0000) return {32'h4040_0000, 8'h00};
      if (op == FPU_MUL && a == 32'h4040_0000 && b == 32'h4000_0000) return {32'h40C0_0000, 8'h00};
      if (op == FPU_SUB && a == b) return {32'h0000_0000, 8'h01};
      if (op == FPU_DIV && b == 32'h0) return {32'h7F80_0000, 8'h22};
      return {a ^ {b[15:0], b[31:16]} ^ {29'd0, op}, a[7:0] ^ b[15:8]};
   endfunction

   logic [39:0] core_q [FPU_LAT];
   always @(posedge clk) begin
      core_q[0] <= fpu_model(fpu_op, fpu_opa, fpu_opb);
      for (int k = 1; k < FPU_LAT; k++) core_q[k] <= core_q[k-1];
   end
   assign fpu_out   = core_q[FPU_LAT-1][39:8];
   assign fpu_flags = core_q[FPU_LAT-1][7:0];

   typedef struct {
      logic [2:0]       op;
      logic [31:0]      a;
      logic [31:0]      b;
      logic [TAG_W-1:0] tag;
      logic [31:0]      res;
      logic [7:0]       flg;
   } vec_t;

   typedef struct packed {
      logic [31:0]      res;
      logic [7:0]       flg;
      logic [TAG_W-1:0] tag;
   } exp_t;

   vec_t        vec [6];
   exp_t        sb [$];
   int          errors = 0;
   int          checks = 0;
   logic        last_acc;
   logic [31:0] exp_res;
   logic [7:0]  exp_flg;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, req);
      end
   endtask

   // One clock: observe handshakes at the falling edge, then step past the rising edge.
   task automatic tick();
      exp_t e;
      @(negedge clk);
      last_acc = 1'b0;
      if (rst) begin
         sb.delete();
      end else begin
         if (rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_rsp actual tag=%0d required no response", rsp_tag);
            end else begin
               e = sb.pop_front();
               chk("rsp_result", rsp_result, e.res);
               chk("rsp_flags", rsp_flags, e.flg);
               chk("rsp_tag", rsp_tag, e.tag);
            end
         end
         if (req_valid && req_ready) begin
            sb.push_back({exp_res, exp_flg, req_tag});
            last_acc = 1'b1;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input vec_t v);
      req_valid = 1'b1;
      req_op    = v.op;
      req_opa   = v.a;
      req_opb   = v.b;
      req_tag   = v.tag;
      exp_res   = v.res;
      exp_flg   = v.flg;
   endtask

   function automatic vec_t mkvec(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input int tag);
      vec_t v;
      logic [39:0] r;
      r     = fpu_model(op, a, b);
      v.op  = op;
      v.a   = a;
      v.b   = b;
      v.tag = TAG_W'(tag);
      v.res = r[39:8];
      v.flg = r[7:0];
      return v;
   endfunction

   task automatic drain(input string nm);
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      for (int i = 0; i < 40; i++) begin
         if (sb.size() == 0 && !busy && !rsp_valid) break;
         tick();
      end
      chk(nm, {sb.size() == 0, busy, rsp_valid}, 3'b100);
   endtask

   task automatic wait_rsp(input string nm);
      int w = 0;
      while (!rsp_valid && w < 20) begin
         tick();
         w++;
      end
      chk(nm, rsp_valid, 1'b1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1);
   end

   initial begin
      int lat;
      int k;
      int seen;

      vec[0] = '{FPU_ADD, 32'h3F80_0000, 32'h4000_0000, 4'd1, 32'h4040_0000, 8'h00};
      vec[1] = '{FPU_MUL, 32'h4040_0000, 32'h4000_0000, 4'd2, 32'h40C0_0000, 8'h00};
      vec[2] = '{FPU_SUB, 32'h3F80_0000, 32'h3F80_0000, 4'd3, 32'h0000_0000, 8'h01};
      vec[3] = '{FPU_DIV, 32'h3F80_0000, 32'h0000_0000, 4'd4, 32'h7F80_0000, 8'h22};
      vec[4] = '{3'd5,    32'h3F80_0000, 32'h4000_0000, 4'd7, 32'h7FC0_0000, 8'h40};
      vec[5] = '{FPU_ADD, 32'h3F80_0000, 32'h4000_0000, 4'd9, 32'h4040_0000, 8'h00};

      rst = 1'b1; req_valid = 1'b0; req_op = '0; req_rmode = RM_NEAREST;
      req_opa = '0; req_opb = '0; req_tag = '0; rsp_ready = 1'b0;
      exp_res = '0; exp_flg = '0;
      tick();
      tick();
      chk("rst_req_ready", req_ready, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_rsp_valid", rsp_valid, 1'b0);
      chk("rst_fpu_op", fpu_op, 3'd0);
      chk("rst_fpu_opa", fpu_opa, 32'd0);
      chk("rst_rsp_result", rsp_result, 32'd0);
      rst = 1'b0;
      tick();
      chk("rel_req_ready", req_ready, 1'b1);

      // Basic add and first-response latency.
      rsp_ready = 1'b1;
      req_rmode = RM_ZERO;
      drive(vec[0]);
      tick();
      chk("t1_accept", last_acc, 1'b1);
      chk("t1_fpu_rmode", fpu_rmode, RM_ZERO);
      req_valid = 1'b0;
      lat = 0;
      while (!rsp_valid && lat < 20) begin
         tick();
         lat++;
      end
      chk("t1_latency", lat, FPU_LAT + 1);
      chk("t1_result", rsp_result, vec[0].res);
      drain("t1_drain");

      // Back-to-back mix, responses on consecutive cycles.
      for (int i = 1; i <= 3; i++) begin
         drive(vec[i]);
         chk("t2_req_ready", req_ready, 1'b1);
         tick();
         chk("t2_accept", last_acc, 1'b1);
      end
      req_valid = 1'b0;
      wait_rsp("t2_wait");
      for (int i = 1; i <= 3; i++) begin
         chk("t2_rsp_valid", rsp_valid, 1'b1);
         chk("t2_order_tag", rsp_tag, vec[i].tag);
         tick();
      end
      drain("t2_drain");

      // Backpressure: only DEPTH ops fit until responses are consumed.
      rsp_ready = 1'b0;
      k = 0;
      for (int c = 0; c < 12; c++) begin
         drive(mkvec(FPU_MUL, 32'h4000_0000 + 32'(k), 32'h3F80_0000, k));
         tick();
         if (last_acc) k++;
      end
      chk("t3_accepted", k, DEPTH);
      chk("t3_req_ready_low", req_ready, 1'b0);
      chk("t3_head_tag", {rsp_valid, rsp_tag}, {1'b1, 4'd0});
      rsp_ready = 1'b1;
      for (int c = 0; c < 30 && k < 6; c++) begin
         drive(mkvec(FPU_MUL, 32'h4000_0000 + 32'(k), 32'h3F80_0000, k));
         tick();
         if (last_acc) k++;
      end
      chk("t3_all_accepted", k, 6);
      drain("t3_drain");

      // Illegal op: core sees an add, response is the canonical qNaN.
      drive(vec[4]);
      tick();
      chk("t4_accept", last_acc, 1'b1);
      chk("t4_fpu_op", fpu_op, 3'd0);
      chk("t4_fpu_opa", fpu_opa, vec[4].a);
      drain("t4_drain");

      // Reset with three ops in flight.
      for (int i = 1; i <= 3; i++) begin
         drive(vec[i]);
         tick();
      end
      req_valid = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("t5_busy_in_rst", busy, 1'b0);
      chk("t5_ready_in_rst", req_ready, 1'b0);
      tick();
      chk("t5_ready_rel", req_ready, 1'b1);
      chk("t5_busy_rel", busy, 1'b0);
      seen = 0;
      for (int i = 0; i < 10; i++) begin
         if (rsp_valid) seen++;
         tick();
      end
      chk("t5_no_stale_rsp", seen, 0);
      drive(vec[5]);
      tick();
      chk("t5_accept", last_acc, 1'b1);
      drain("t5_drain");

      // Pop coinciding with a FIFO write, then pop coinciding with an issue.
      rsp_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         drive(mkvec(FPU_ADD, 32'h4100_0000 + 32'(i), 32'h0000_0001, 10 + i));
         tick();
      end
      req_valid = 1'b0;
      for (int i = 0; i < 6; i++) tick();
      chk("t6_ready_3buf", req_ready, 1'b1);
      drive(mkvec(FPU_ADD, 32'h4100_0003, 32'h0000_0001, 13));
      tick();
      chk("t6_accept4", last_acc, 1'b1);
      chk("t6_ready_full", req_ready, 1'b0);
      req_valid = 1'b0;
      for (int i = 0; i < FPU_LAT; i++) tick();
      chk("t6_head_stable", {rsp_valid, rsp_tag}, {1'b1, 4'd10});
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      chk("t6_ready_after_pop", req_ready, 1'b1);
      chk("t6_head_next", rsp_tag, 4'd11);
      drive(mkvec(FPU_MUL, 32'h4100_0004, 32'h0000_0001, 14));
      rsp_ready = 1'b1;
      tick();
      chk("t6_accept5", last_acc, 1'b1);
      chk("t6_ready_issue_pop", req_ready, 1'b1);
      chk("t6_head_after", rsp_tag, 4'd12);
      drain("t6_drain");

      chk("final_sb_empty", sb.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/fpu_issue_ctrl.md
Name: fpu_issue_ctrl

Overview:
Synthesizable initiator for the existing fixed-latency, non-stallable fpu core. It takes operation requests over a valid/ready interface and registers them onto the fpu operand/op/rmode inputs. It tracks in-flight operations with a latency-matched valid/tag pipeline and returns results plus the 8 exception flags, in order, through a valid/ready response FIFO. Credit accounting guarantees that no fpu result is ever dropped.

Parameters:
FPU_LAT, 4, cycles from the fpu input register update to a valid fpu_out (must match the core).
DEPTH, 4, response FIFO entries; also the maximum in-flight plus buffered operations.
TAG_W, 4, width of the request tag carried to the response.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  request accepted when high with req_valid
req_op  in  3  0 add, 1 sub, 2 mul, 3 div; 4-7 illegal
req_rmode  in  2  rounding mode, passed through
req_opa  in  32  IEEE-754 single operand A
req_opb  in  32  IEEE-754 single operand B
req_tag  in  TAG_W  opaque id
fpu_op  out  3  to core
fpu_rmode  out  2  to core
fpu_opa  out  32  to core
fpu_opb  out  32  to core
fpu_out  in  32  from core
fpu_flags  in  8  {snan,qnan,inf,ine,overflow,underflow,div_by_zero,zero} from core
rsp_valid  out  1  response present
rsp_ready  in  1  consumer accepts
rsp_result  out  32  result word
rsp_flags  out  8  same bit order as fpu_flags
rsp_tag  out  TAG_W  tag of the originating request
busy  out  1  high while any operation is in flight or buffered

Behaviour:
- Reset (rst=1 at an edge): fpu_op/rmode/opa/opb, the pipeline, the FIFO and the credit count are all cleared. All outputs read 0, including req_ready in the cycle following reset. In-flight operations are discarded; none of them produce a response after reset.
- Credit count: credits = in-flight + FIFO occupancy. req_ready = (credits < DEPTH). It is combinational from registered state and never depends on req_valid.
- Issue on edge E (req_valid & req_ready):
  - fpu_* registers load req_*; for an illegal op, fpu_op loads 0.
  - Pipeline stage 0 loads {1, illegal, tag}.
  - Without an accept, the fpu_* registers hold their value.
- Pipeline: a shift register FPU_LAT+1 deep that advances every edge. At depth FPU_LAT the entry aligns with fpu_out and fpu_flags. It is written into the FIFO on the next edge (E+FPU_LAT+1).
  - Legal op: write {fpu_out, fpu_flags, tag}.
  - Illegal op: write {32'h7FC00000, 8'b0100_0000, tag}.
- Latency: with an empty FIFO, rsp_valid rises FPU_LAT+1 edges after the accept edge. Throughput is 1 op/cycle while credits are available.
- FIFO: registered storage with show-ahead. rsp_* reflect the head entry; they are stable while rsp_valid & !rsp_ready. A pop occurs on rsp_valid & rsp_ready.
- Simultaneous issue and pop: credits unchanged. Simultaneous FIFO write and pop are both honoured, including when the FIFO is full or has one entry. A write never occurs into a full FIFO, because credits prevent it.
- Ordering: responses always leave in issue order, whatever the mix of ops and stalls.
- busy = (credits != 0).
- Back-to-back: after reset is released, req_ready is high in the next cycle.

Decomposition:
- Shared package fpu_pkg holds:
  - op constants FPU_ADD=0, FPU_SUB=1, FPU_MUL=2, FPU_DIV=3;
  - rmode constants RM_NEAREST=0, RM_ZERO=1, RM_PINF=2, RM_NINF=3;
  - flag bit indices;
  - canonical QNAN constant 32'h7FC00000;
  - the response entry struct {result, flags, tag}.
- One sub-module, fpu_rsp_fifo (parameterized WIDTH/DEPTH, sync reset, show-ahead, count output used for credits). The pipeline and credit logic stay in fpu_issue_ctrl.

Test Plan:
1. Basic add: accept op=0, opa=3F800000, opb=40000000, tag=1, rsp_ready=1. Expect rsp_valid exactly FPU_LAT+1 edges later with result 40400000, flags 0, tag 1.
2. Streaming mix: issue back-to-back on consecutive cycles:
   - 3.0*2.0 (tag 2) -> 40C00000;
   - 1.0-1.0 (tag 3) -> 00000000 with zero flag;
   - 1.0/0.0 (tag 4) -> 7F800000 with inf and div_by_zero.
   Expect in-order responses on consecutive cycles and req_ready high throughout.
3. Backpressure: DEPTH=4, rsp_ready=0, req_valid held for 6 requests (tags 0-5). Expect exactly tags 0-3 accepted and req_ready low. Then raise rsp_ready: expect tags 0-3 in order, and tags 4-5 accepted as credits free.
4. Illegal op: op=5, tag 7. Expect response 7FC00000, flags 40, tag 7, and fpu_op registered as 0.
5. Reset mid-flight: issue 3 ops, assert rst for 1 cycle two edges later. Expect no rsp_valid afterwards, busy=0 and req_ready=1 after release. A subsequent 1.0+2.0 still returns 40400000.
6. Full-FIFO pop+write: fill to DEPTH-1 buffered + 1 in flight, then pulse rsp_ready on the cycle the in-flight result lands. Expect no loss, correct order, and credits consistent.
